masked_pipe: RTL and testbench

Parametrised successor to our two-flop capture/mask/recapture timing circuit. A WIDTH-bit input word is captured, masked bitwise by a side operand `b` at a configurable stage, and carried through STAGES registers to `y`. Generalises the fixed 1-bit, 2-flop path to arbitrary width and depth, and adds a valid/ready elastic handshake, a flush, an occupancy count, and an optional inverted mask. It gives the STA exercises multi-stage register-to-register paths with realistic enable and stall logic.

---
 rtl/masked_pipe_pkg.sv | 22 ++
 rtl/masked_pipe_stage.sv | 37 +++
 rtl/masked_pipe.sv | 88 ++++++++
 tb/tb_masked_pipe.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/masked_pipe_pkg.sv
// masked_pipe_pkg: shared constants and helpers for the masked pipeline.
//   INV_OFF / INV_ON : values for the INVERT parameter
//   lvl_w()          : width of the occupancy count for a given depth
//   params_ok()      : parameter legality, checked at elaboration by the top
package masked_pipe_pkg;

  localparam int INV_OFF = 0;
  localparam int INV_ON  = 1;

  // Occupancy ranges 0..STAGES inclusive.
  function automatic int lvl_w(input int stages);
    return $clog2(stages + 1);
  endfunction

  function automatic bit params_ok(input int width, input int stages,
                                   input int mask_stage, input int invert);
    return (width >= 1) && (stages >= 2) &&
           (mask_stage >= 1) && (mask_stage <= stages - 1) &&
           (invert == INV_OFF || invert == INV_ON);
  endfunction

endpackage

// File: rtl/masked_pipe_stage.sv
// masked_pipe_stage: one valid/data register slice of the elastic pipe.
//   clk   : clock (rising edge)
//   rb    : synchronous active-low reset, clears valid and data
//   load  : a word arrives this cycle; take din and become valid
//   din   : incoming word
//   hold  : this slice is not handing its word downstream
//   clear : flush; drop the valid bit, data left as-is
//   v, d  : registered valid bit and data
module masked_pipe_stage #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rb,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  input  logic             hold,
  input  logic             clear,
  output logic             v,
  output logic [WIDTH-1:0] d
);

  always_ff @(posedge clk) begin
    if (!rb) begin
      v <= 1'b0;
      d <= '0;
    end else if (clear) begin
      v <= 1'b0;
    end else if (load) begin
      v <= 1'b1;
      d <= din;
    end else if (!hold) begin
      // word left downstream and nothing replaced it
      v <= 1'b0;
    end
  end

endmodule

// File: rtl/masked_pipe.sv
// masked_pipe: STAGES-deep elastic register pipe; the word is ANDed (or
// NANDed when INVERT=INV_ON) with b as it moves from slice MASK_STAGE to
// slice MASK_STAGE+1.
//   clk, rb              : clock, synchronous active-low reset
//   flush                : drop all in-flight words at the next edge
//   in_valid/in_ready/a  : upstream handshake and word
//   b                    : mask operand, used combinationally at transfer
//   out_valid/out_ready/y: downstream handshake and word (registered)
//   level                : number of valid slices
module masked_pipe
  import masked_pipe_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int STAGES     = 2,
  parameter int MASK_STAGE = 1,
  parameter int INVERT     = INV_OFF
) (
  input  logic                       clk,
  input  logic                       rb,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           a,
  input  logic [WIDTH-1:0]           b,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           y,
  output logic [lvl_w(STAGES)-1:0]   level
);

  localparam int LW = lvl_w(STAGES);

  if (!params_ok(WIDTH, STAGES, MASK_STAGE, INVERT)) begin : g_bad_params
    $error("masked_pipe: illegal WIDTH/STAGES/MASK_STAGE/INVERT");
  end

  logic [STAGES:1]            v, adv, load;
  logic [STAGES:1][WIDTH-1:0] d, din;
  logic [WIDTH-1:0]           mk;

  // Advance chain walks from the tail back so a stalled tail only blocks
  // the slices directly behind it; bubbles further up still collapse.
  always_comb begin
    adv         = '0;
    adv[STAGES] = v[STAGES] & out_ready;
    for (int i = STAGES - 1; i >= 1; i--)
      adv[i] = v[i] & (~v[i+1] | adv[i+1]);
  end

  assign in_ready = ~flush & (~v[1] | adv[1]);

  // b is deliberately unregistered: the value on the crossing cycle wins.
  assign mk = (INVERT == INV_ON) ? ~(d[MASK_STAGE] & b) : (d[MASK_STAGE] & b);

  always_comb begin
    load    = '0;
    din     = '0;
    load[1] = in_valid & in_ready;
    din[1]  = a;
    for (int i = 2; i <= STAGES; i++) begin
      load[i] = adv[i-1];
      din[i]  = (i - 1 == MASK_STAGE) ? mk : d[i-1];
    end
  end

  for (genvar i = 1; i <= STAGES; i++) begin : g_stage
    masked_pipe_stage #(.WIDTH(WIDTH)) u_stage (
      .clk   (clk),
      .rb    (rb),
      .load  (load[i]),
      .din   (din[i]),
      .hold  (~adv[i]),
      .clear (flush),
      .v     (v[i]),
      .d     (d[i])
    );
  end

  assign out_valid = v[STAGES];
  assign y         = d[STAGES];

  always_comb begin
    level = '0;
    for (int i = 1; i <= STAGES; i++)
      level = level + LW'(v[i]);
  end

endmodule

// File: tb/tb_masked_pipe.sv
module tb_masked_pipe;
  import masked_pipe_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rb;

  // u2 / u2i: 2-stage, shared stimulus, AND vs NAND
  logic       fl2, iv2, or2;
  logic [7:0] a2, b2;
  logic       ir2, ov2, ir2i, ov2i;
  logic [7:0] y2, y2i;
  logic [1:0] lv2, lv2i;
  // u4: 4-stage, mask between slices 2 and 3
  logic       fl4, iv4, or4;
  logic [7:0] a4, b4;
  logic       ir4, ov4;
  logic [7:0] y4;
  logic [2:0] lv4;

  masked_pipe #(.WIDTH(8), .STAGES(2), .MASK_STAGE(1), .INVERT(INV_OFF)) u2 (
    .clk(clk), .rb(rb), .flush(fl2), .in_valid(iv2), .in_ready(ir2), .a(a2), .b(b2),
    .out_valid(ov2), .out_ready(or2), .y(y2), .level(lv2));
  masked_pipe #(.WIDTH(8), .STAGES(2), .MASK_STAGE(1), .INVERT(INV_ON)) u2i (
    .clk(clk), .rb(rb), .flush(fl2), .in_valid(iv2), .in_ready(ir2i), .a(a2), .b(b2),
    .out_valid(ov2i), .out_ready(or2), .y(y2i), .level(lv2i));
  masked_pipe #(.WIDTH(8), .STAGES(4), .MASK_STAGE(2), .INVERT(INV_OFF)) u4 (
    .clk(clk), .rb(rb), .flush(fl4), .in_valid(iv4), .in_ready(ir4), .a(a4), .b(b4),
    .out_valid(ov4), .out_ready(or4), .y(y4), .level(lv4));

  int checks = 0;
  int failures = 0;
  logic [7:0] q2[$], q2i[$], q4[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitors: pop on every handshake seen at the falling edge.
  always @(negedge clk) begin
    if (rb && ov2 && or2) begin
      if (q2.size() == 0) begin
        checks++; failures++;
        $display("FAIL y2_unexpected got=%0h want=none", y2);
      end else chk("y2", y2, q2.pop_front());
    end
    if (rb && ov2i && or2) begin
      if (q2i.size() == 0) begin
        checks++; failures++;
        $display("FAIL y2i_unexpected got=%0h want=none", y2i);
      end else chk("y2i", y2i, q2i.pop_front());
    end
    if (rb && ov4 && or4) begin
      if (q4.size() == 0) begin
        checks++; failures++;
        $display("FAIL y4_unexpected got=%0h want=none", y4);
      end else chk("y4", y4, q4.pop_front());
    end
  end

  logic [7:0] w4 [5];
  logic [7:0] s2a [3];
  logic [7:0] s2e [3];
  logic [7:0] s2ie[3];

  initial begin
    w4   = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    s2a  = '{8'h12, 8'h34, 8'h56};
    s2e  = '{8'h10, 8'h34, 8'h14};   // a & 3C
    s2ie = '{8'hEF, 8'hCB, 8'hEB};   // ~(a & 3C)

    rb = 1'b0; fl2 = 0; iv2 = 0; or2 = 0; a2 = 0; b2 = 0;
    fl4 = 0; iv4 = 0; or4 = 0; a4 = 0; b4 = 0;
    repeat (3) cyc;
    rb = 1'b1;
    #1;
    chk("rst_ov2", ov2, 0); chk("rst_y2", y2, 0); chk("rst_lv2", lv2, 0); chk("rst_ir2", ir2, 1);
    chk("rst_ov4", ov4, 0); chk("rst_y4", y4, 0); chk("rst_lv4", lv4, 0); chk("rst_ir4", ir4, 1);

    // single word through the 2-stage pipes
    cyc; a2 = 8'hF0; b2 = 8'h3C; iv2 = 1; or2 = 1;
    q2.push_back(8'h30); q2i.push_back(8'hCF);
    #1; chk("t1_ir", ir2, 1); chk("t1_lv0", lv2, 0);
    cyc; iv2 = 0; #1; chk("t1_lv_a", lv2, 1); chk("t1_ov_a", ov2, 0);
    cyc; #1; chk("t1_lv_b", lv2, 1); chk("t1_ov_b", ov2, 1);
    cyc; #1; chk("t1_lv_c", lv2, 0); chk("t1_ov_c", ov2, 0);

    // inverted-mask word
    cyc; a2 = 8'hFF; b2 = 8'h0F; iv2 = 1;
    q2.push_back(8'h0F); q2i.push_back(8'hF0);
    cyc; iv2 = 0;
    repeat (2) cyc;

    // back-to-back stream, one word per cycle
    for (int k = 0; k < 3; k++) begin
      cyc; a2 = s2a[k]; b2 = 8'h3C; iv2 = 1;
      q2.push_back(s2e[k]); q2i.push_back(s2ie[k]);
      #1; chk("t2_ir", ir2, 1);
    end
    cyc; iv2 = 0;
    repeat (3) cyc;
    chk("t2_lv", lv2, 0);

    // fill the 4-stage pipe with the tail blocked
    or4 = 0; b4 = 8'hF0;
    for (int k = 0; k < 5; k++) begin
      cyc; a4 = w4[k]; iv4 = 1;
      #1; chk("t3_ir", ir4, (k < 4) ? 1 : 0);
      if (k < 4) q4.push_back(w4[k] & 8'hF0);
    end
    chk("t3_full_lv", lv4, 4); chk("t3_full_y", y4, 8'h10); chk("t3_full_ov", ov4, 1);
    cyc; #1; chk("t3_stable_y", y4, 8'h10); chk("t3_stable_ov", ov4, 1); chk("t3_stable_ir", ir4, 0);
    or4 = 1; #1; chk("t3_ir_release", ir4, 1);
    q4.push_back(8'h50);
    cyc; iv4 = 0; #1; chk("t3_lv_accept_emit", lv4, 4);
    repeat (5) cyc;
    chk("t3_drain_lv", lv4, 0);

    // bubble between two words, tail blocked
    or4 = 0; b4 = 8'hF0;
    cyc; a4 = 8'hA1; iv4 = 1; q4.push_back(8'hA0);
    cyc; iv4 = 0;
    cyc; a4 = 8'hB2; iv4 = 1; q4.push_back(8'hB0);
    cyc; iv4 = 0; #1; chk("t4_lv_a", lv4, 2);
    cyc; #1; chk("t4_lv_b", lv4, 2); chk("t4_ir", ir4, 1);
    cyc; #1; chk("t4_ov", ov4, 1); chk("t4_y", y4, 8'hA0); chk("t4_lv_c", lv4, 2);
    or4 = 1;
    repeat (4) cyc;
    chk("t4_drain_lv", lv4, 0);

    // b changes while the third word waits in front of the mask point
    or4 = 0; b4 = 8'hFF;
    cyc; a4 = 8'h5A; iv4 = 1; q4.push_back(8'h5A);
    cyc; a4 = 8'hA5;          q4.push_back(8'hA5);
    cyc; a4 = 8'hFF;          q4.push_back(8'h3C);
    cyc; iv4 = 0;
    cyc; b4 = 8'h0F; #1; chk("t5_lv", lv4, 3);
    cyc;
    cyc; #1; chk("t5_stall_lv", lv4, 3); chk("t5_stall_y", y4, 8'h5A);
    b4 = 8'h3C; or4 = 1;
    cyc; b4 = 8'h00;
    repeat (3) cyc;
    chk("t5_drain_lv", lv4, 0);

    // flush with three words in flight and a word offered
    or4 = 0; b4 = 8'hF0;
    cyc; a4 = 8'h01; iv4 = 1;
    cyc; a4 = 8'h02;
    cyc; a4 = 8'h03;
    cyc; a4 = 8'h04; fl4 = 1;
    #1; chk("t6_ir_flush", ir4, 0); chk("t6_lv_pre", lv4, 3);
    cyc; fl4 = 0; iv4 = 0;
    #1; chk("t6_lv", lv4, 0); chk("t6_ov", ov4, 0);
    cyc; #1; chk("t6_lv_after", lv4, 0);

    // reset mid-stream
    cyc; a4 = 8'h77; iv4 = 1;
    cyc; a4 = 8'h88;
    cyc; a4 = 8'h99;
    cyc; iv4 = 0;
    cyc; #1; chk("t7_y_pre", y4, 8'h70); chk("t7_lv_pre", lv4, 3);
    a4 = 8'hAA; iv4 = 1; rb = 0;
    cyc; rb = 1; iv4 = 0;
    #1; chk("t7_lv", lv4, 0); chk("t7_ov", ov4, 0); chk("t7_y", y4, 0);
    chk("t7_y2", y2, 0); chk("t7_ir", ir4, 1);

    // pipe still works afterwards
    or4 = 1; b4 = 8'hF0;
    cyc; a4 = 8'hD5; iv4 = 1; q4.push_back(8'hD0);
    cyc; iv4 = 0;
    repeat (4) cyc;
    chk("t8_lv", lv4, 0);

    chk("q2_empty", q2.size(), 0);
    chk("q2i_empty", q2i.size(), 0);
    chk("q4_empty", q4.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
